sdram_frame_writer: RTL

- Upstream stage of the SDRAM controller on the camera write path.
- Buffers the 16-bit RGB565 pixel stream from the camera capture stage in a local FIFO.
- Issues one full-page write (512 words) to the controller each time a page is buffered, with a linear row/bank page address.
- Pixels arrive already in the controller's 165 MHz domain as a qualified strobe; this block does no clock-domain crossing.

---
 rtl/sdram_pkg.sv | 38 +++
 rtl/sdram_burst_fifo.sv | 64 ++++++
 rtl/sdram_frame_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Definitions shared by the SDRAM controller and its camera write path:
//   page-burst length, page address field widths, controller command
//   encodings and the frame writer state enum.
//   No ports (package).

package sdram_pkg;

  // Full-page burst length of the controller's page mode.
  localparam int BURST_LEN   = 512;

  // Page address layout: f_addr = {row, bank}; column comes from the burst.
  localparam int ROW_W       = 13;
  localparam int BANK_W      = 2;
  localparam int COL_W       = 9;
  localparam int PAGE_ADDR_W = ROW_W + BANK_W;

  // Controller command encoding {cs_n, ras_n, cas_n, we_n}.
  typedef enum logic [3:0] {
    CMD_LMR       = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_BST       = 4'b0110,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

  // Frame writer request sequencing.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    ADV
  } wr_state_e;

endpackage

// File: rtl/sdram_burst_fifo.sv
// sdram_burst_fifo
//   Synchronous show-ahead FIFO. rd_data always presents the head entry
//   straight from storage. A push while full is accepted when a pop happens
//   in the same cycle; pops while empty are ignored.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wr_data   write strobe and data
//   pop             remove head entry
//   rd_data         head entry (zero latency)
//   level           occupancy, 0..DEPTH
//   full, empty     occupancy flags

module sdram_burst_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer
//   Camera write path ahead of the SDRAM controller. Buffers RGB565 pixels
//   and issues one full-page write per buffered page, walking a linear
//   {row, bank} page address that restarts at FRAME_BASE on each frame.
//   Optional statistics outputs are enabled by SDRAM_FRAME_WRITER_STATS_EN.
// Ports:
//   clk, rst            165 MHz clock, asynchronous active-high reset
//   pix_data/pix_valid  qualified pixel stream
//   frame_start         vsync pulse; restarts the page address
//   rw, rw_en, f_addr   write request to the controller
//   f2s_data            FIFO head, consumed on f2s_data_valid
//   f2s_data_valid      controller takes f2s_data this edge
//   ready               controller accepts a request
//   fifo_level          FIFO occupancy
//   overflow            sticky pixel drop flag
//   busy                request or burst in flight
//   drop_count          (stats) saturating dropped pixel count
//   frame_count         (stats) wrapping honoured frame_start count
//
// state | meaning
// IDLE  | apply pending frame restart, or request once a page is buffered
// WAIT  | request issued, waiting for the first data strobe
// BURST | streaming the rest of the page to the controller
// ADV   | step to the next page address, wrap at end of frame

module sdram_frame_writer
  import sdram_pkg::*;
#(
  parameter int                     BURST_LEN       = sdram_pkg::BURST_LEN,
  parameter int                     FIFO_DEPTH      = 1024,
  parameter logic [PAGE_ADDR_W-1:0] FRAME_BASE      = 15'd0,
  parameter int                     PAGES_PER_FRAME = 600
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   pix_data,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  output logic                          rw,
  output logic                          rw_en,
  output logic [PAGE_ADDR_W-1:0]        f_addr,
  output logic [15:0]                   f2s_data,
  input  logic                          f2s_data_valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
`ifdef SDRAM_FRAME_WRITER_STATS_EN
  ,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   frame_count
`endif
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCNT_W = $clog2(BURST_LEN) + 1;
  localparam int PG_W   = $clog2(PAGES_PER_FRAME) + 1;
  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);

  wr_state_e         state;
  logic              frame_pending;
  logic [WCNT_W-1:0] words_left;
  logic [PG_W-1:0]   page_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              drop;
  logic              apply_frame;

  // Strobes outside WAIT/BURST are protocol errors and must not consume data.
  assign fifo_pop    = f2s_data_valid & ~fifo_empty & ((state == WAIT) | (state == BURST));
  assign drop        = pix_valid & fifo_full & ~fifo_pop;
  assign apply_frame = (state == IDLE) & frame_pending;
  assign rw          = 1'b0;
  assign busy        = (state != IDLE);

  sdram_burst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (pix_valid),
    .wr_data (pix_data),
    .pop     (fifo_pop),
    .rd_data (f2s_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rw_en         <= 1'b0;
      f_addr        <= FRAME_BASE;
      page_cnt      <= '0;
      words_left    <= '0;
      frame_pending <= 1'b0;
    end else begin
      rw_en <= 1'b0;
      // A new pulse wins over clearing, so a restart is never lost.
      if (frame_start)      frame_pending <= 1'b1;
      else if (apply_frame) frame_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_pending) begin
            f_addr   <= FRAME_BASE;
            page_cnt <= '0;
          end else if (ready && (fifo_level >= BURST_LVL)) begin
            rw_en <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (fifo_pop) begin
            words_left <= WCNT_W'(BURST_LEN - 1);
            state      <= BURST;
          end
        end
        BURST: begin
          if (fifo_pop) begin
            words_left <= words_left - WCNT_W'(1);
            if (words_left == WCNT_W'(1)) state <= ADV;
          end
        end
        ADV: begin
          if (page_cnt == PG_W'(PAGES_PER_FRAME - 1)) begin
            f_addr   <= FRAME_BASE;
            page_cnt <= '0;
          end else begin
            f_addr   <= f_addr + PAGE_ADDR_W'(1);
            page_cnt <= page_cnt + PG_W'(1);
          end
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SDRAM_FRAME_WRITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (apply_frame) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
